// File: rtl/tick_divider_bank.sv
// Bank of independent programmable tick dividers with periodic/one-shot modes.
// Outputs are registered (tick one cycle after counter == tc); no backpressure, loads always accepted.
module tick_divider_bank #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 25,
  parameter int DEFAULT_TC = 25174013,
  localparam int IW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] i_hold,
  input  logic                i_load,
  input  logic [IW-1:0]       i_load_ch,
  input  logic [WIDTH-1:0]    i_load_tc,
  input  logic                i_load_oneshot,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_toggle,
  output logic [CHANNELS-1:0] o_running
);

  typedef enum logic {
    DONE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TC_RST = WIDTH'(DEFAULT_TC);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             oneshot_q, oneshot_d;
    logic             tick_q, tick_d;
    logic             toggle_q, toggle_d;
    logic             load_hit;
    logic             at_tc;

    // Out-of-range indices never match any channel, so such loads fall through.
    assign load_hit = i_load && (i_load_ch == IW'(c));
    assign at_tc    = (state_q == RUN) && (cnt_q == tc_q);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tc_d      = tc_q;
      oneshot_d = oneshot_q;
      tick_d    = 1'b0;
      toggle_d  = toggle_q;
      if (load_hit) begin
        tc_d      = i_load_tc;
        oneshot_d = i_load_oneshot;
        cnt_d     = '0;
        state_d   = RUN;
      end else if (state_q == RUN) begin
        if (at_tc) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (!i_hold[c]) toggle_d = ~toggle_q;
          if (oneshot_q) state_d = DONE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= RUN;
        cnt_q     <= '0;
        tc_q      <= TC_RST;
        oneshot_q <= 1'b0;
        tick_q    <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        tc_q      <= tc_d;
        oneshot_q <= oneshot_d;
        tick_q    <= tick_d;
        toggle_q  <= toggle_d;
      end
    end

    assign o_tick[c]    = tick_q;
    assign o_toggle[c]  = toggle_q;
    assign o_running[c] = (state_q == RUN);
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank with CHANNELS=3, WIDTH=4, DEFAULT_TC=3.
module tb_tick_divider_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] i_hold = '0;
  logic       i_load = 1'b0;
  logic [1:0] i_load_ch = '0;
  logic [3:0] i_load_tc = '0;
  logic       i_load_oneshot = 1'b0;
  logic [2:0] o_tick, o_toggle, o_running;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tick_divider_bank #(.CHANNELS(3), .WIDTH(4), .DEFAULT_TC(3)) dut (
    .clk(clk), .rst(rst), .i_hold(i_hold), .i_load(i_load),
    .i_load_ch(i_load_ch), .i_load_tc(i_load_tc), .i_load_oneshot(i_load_oneshot),
    .o_tick(o_tick), .o_toggle(o_toggle), .o_running(o_running)
  );

  typedef struct {
    logic       rst;
    logic [2:0] hold;
    logic       ld;
    logic [1:0] ch;
    logic [3:0] tc;
    logic       os;
    logic [2:0] tick;
    logic [2:0] tog;
    logic [2:0] run;
  } vec_t;

  localparam int NV = 42;
  vec_t tbl [NV];

  task automatic row(input int i, input logic r, input logic [2:0] h, input logic ld,
                     input logic [1:0] ch, input logic [3:0] tc, input logic os,
                     input logic [2:0] tk, input logic [2:0] tg);
    tbl[i] = '{rst: r, hold: h, ld: ld, ch: ch, tc: tc, os: os, tick: tk, tog: tg, run: 3'b111};
  endtask

  task automatic drive(input logic r, input logic [2:0] h, input logic ld,
                       input logic [1:0] ch, input logic [3:0] tc, input logic os);
    rst = r; i_hold = h; i_load = ld; i_load_ch = ch; i_load_tc = tc; i_load_oneshot = os;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;

    // Reset release, all channels tick together every 4 cycles
    row(0, 1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
    for (int i = 1; i <= 12; i++) row(i, 0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
    row(4,  0, 3'b000, 0, 0, 0, 0, 3'b111, 3'b111);
    for (int i = 5; i <= 7; i++) row(i, 0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b111);
    row(8,  0, 3'b000, 0, 0, 0, 0, 3'b111, 3'b000);
    row(12, 0, 3'b000, 0, 0, 0, 0, 3'b111, 3'b111);
    // Reset with a simultaneous load (reset wins), then hold on ch1
    row(13, 1, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000);
    for (int i = 14; i <= 16; i++) row(i, 0, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000);
    row(17, 0, 3'b010, 0, 0, 0, 0, 3'b111, 3'b101);
    for (int i = 18; i <= 20; i++) row(i, 0, 3'b010, 0, 0, 0, 0, 3'b000, 3'b101);
    row(21, 0, 3'b010, 0, 0, 0, 0, 3'b111, 3'b000);
    // ch0 tc=0 periodic, hold with tc=0, invalid-channel load, load at counter==tc
    row(22, 0, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000);
    row(23, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b001);
    row(24, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b000);
    row(25, 0, 3'b000, 0, 0, 0, 0, 3'b111, 3'b111);
    row(26, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b110);
    row(27, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b111);
    row(28, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b110);
    row(29, 0, 3'b000, 0, 0, 0, 0, 3'b111, 3'b001);
    row(30, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001);
    row(31, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b000);
    row(32, 0, 3'b000, 1, 3, 1, 1, 3'b001, 3'b001);
    row(33, 0, 3'b000, 0, 0, 0, 0, 3'b111, 3'b110);
    row(34, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b111);
    row(35, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b110);
    row(36, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b111);
    row(37, 0, 3'b000, 1, 1, 2, 0, 3'b101, 3'b010);
    row(38, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b011);
    row(39, 0, 3'b000, 0, 0, 0, 0, 3'b001, 3'b010);
    row(40, 0, 3'b000, 0, 0, 0, 0, 3'b011, 3'b001);
    row(41, 0, 3'b000, 0, 0, 0, 0, 3'b101, 3'b100);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].ld, tbl[i].ch, tbl[i].tc, tbl[i].os);
      chk($sformatf("row%0d tick", i),    8'(o_tick),    8'(tbl[i].tick));
      chk($sformatf("row%0d toggle", i),  8'(o_toggle),  8'(tbl[i].tog));
      chk($sformatf("row%0d running", i), 8'(o_running), 8'(tbl[i].run));
    end

    // One-shot tc=5 on ch2: single tick 6 edges after the load edge
    drive(0, 3'b000, 1, 2, 5, 1);
    chk("os5 load running", 8'(o_running[2]), 8'd1);
    chk("os5 load tick", 8'(o_tick[2]), 8'd0);
    n = 0;
    found = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      drive(0, 3'b000, 0, 0, 0, 0);
      if (o_tick[2] === 1'b1) begin
        found = 1;
        n = k;
      end
    end
    chk("os5 tick edge", 8'(n), 8'd6);
    chk("os5 running fall", 8'(o_running[2]), 8'd0);
    for (int k = 0; k < 20; k++) begin
      drive(0, 3'b000, 0, 0, 0, 0);
      chk($sformatf("os5 done cyc%0d", k), 8'({o_tick[2], o_running[2]}), 8'd0);
    end
    // Rearm with tc=1, then tc=0
    drive(0, 3'b000, 1, 2, 1, 1);
    chk("os1 rearm running", 8'(o_running[2]), 8'd1);
    drive(0, 3'b000, 0, 0, 0, 0);
    chk("os1 edge1 tick", 8'(o_tick[2]), 8'd0);
    drive(0, 3'b000, 0, 0, 0, 0);
    chk("os1 edge2 tick/run", 8'({o_tick[2], o_running[2]}), 8'b10);
    drive(0, 3'b000, 1, 2, 0, 1);
    chk("os0 load tick/run", 8'({o_tick[2], o_running[2]}), 8'b01);
    drive(0, 3'b000, 0, 0, 0, 0);
    chk("os0 edge1 tick/run", 8'({o_tick[2], o_running[2]}), 8'b10);
    drive(0, 3'b000, 0, 0, 0, 0);
    chk("os0 edge2 tick/run", 8'({o_tick[2], o_running[2]}), 8'b00);

    // Reset mid-count with toggle=101 and ch2 in DONE
    drive(1, 3'b010, 0, 0, 0, 0);
    drive(0, 3'b010, 1, 2, 5, 1);
    for (int k = 2; k <= 6; k++) drive(0, 3'b010, 0, 0, 0, 0);
    drive(0, 3'b010, 0, 0, 0, 0);
    chk("pre-rst toggle", 8'(o_toggle), 8'b101);
    chk("pre-rst running", 8'(o_running), 8'b011);
    chk("pre-rst tick", 8'(o_tick), 8'b100);
    drive(1, 3'b010, 1, 0, 0, 0);
    chk("rst tick", 8'(o_tick), 8'b000);
    chk("rst toggle", 8'(o_toggle), 8'b000);
    chk("rst running", 8'(o_running), 8'b111);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 3'b000, 0, 0, 0, 0);
      chk($sformatf("post-rst edge%0d tick", k), 8'(o_tick), 8'b000);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    chk("post-rst edge4 tick", 8'(o_tick), 8'b111);
    chk("post-rst edge4 toggle", 8'(o_toggle), 8'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
